// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver: shadowed BCD digits, leading-zero blanking, per-digit dp and blink.
// Latency: seg_out/dig_sel registered one cycle behind the scan index; new data takes effect at the next frame boundary.
// Backpressure: none; load is accepted every cycle and the latest load before a frame boundary wins.
//
// Ports:
//   clk, rst_n       clock (rising edge) and async active-low reset
//   load             1-cycle strobe capturing bcd_in/dp_in/blink_in/blank_lz
//   bcd_in           DIGITS packed BCD digits, digit i = bcd_in[4i+3:4i] (digit 0 rightmost)
//   dp_in, blink_in  per-digit decimal point / blink enable
//   blank_lz         suppress leading zeros
//   seg_out          {dp,a,b,c,d,e,f,g}, active-high, registered
//   dig_sel          one-hot digit enable, polarity set by DIG_ACT_LOW, registered
//   frame_stb        1-cycle pulse when dig_sel first selects digit 0 of a new frame
module seg7_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64,
    parameter bit DIG_ACT_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic [DIGITS-1:0]   blink_in,
    input  logic                blank_lz,
    output logic [7:0]          seg_out,
    output logic [DIGITS-1:0]   dig_sel,
    output logic                frame_stb
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [FW-1:0]       fcnt;
    logic                phase;
    logic                wrap_d;

    // Pending copy collects loads during a frame; shadow is what is on display.
    logic [4*DIGITS-1:0] pend_bcd, sh_bcd;
    logic [DIGITS-1:0]   pend_dp, sh_dp;
    logic [DIGITS-1:0]   pend_blink, sh_blink;
    logic                pend_lz, sh_lz;
    logic                pend_vld;

    logic                tc, last, wrap;
    logic [3:0]          cur_bcd;
    logic                cur_dp, cur_bl, cur_lead;
    logic                upper_zero;
    logic [DIGITS-1:0]   onehot;
    logic [7:0]          seg_next;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h7E;
            4'd1:    decode = 7'h30;
            4'd2:    decode = 7'h6D;
            4'd3:    decode = 7'h79;
            4'd4:    decode = 7'h33;
            4'd5:    decode = 7'h5B;
            4'd6:    decode = 7'h5F;
            4'd7:    decode = 7'h70;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h7B;
            default: decode = 7'h00;
        endcase
    endfunction

    assign tc   = (cnt == CW'(SCAN_DIV - 1));
    assign last = (idx == IW'(DIGITS - 1));
    // Last cycle of the last digit: the frame boundary where shadow data may change.
    assign wrap = tc && last;

    // Select the current digit; walking from the top digit down tracks whether
    // this digit and all higher ones are zero (leading-zero candidate).
    always_comb begin
        cur_bcd    = 4'd0;
        cur_dp     = 1'b0;
        cur_bl     = 1'b0;
        cur_lead   = 1'b0;
        upper_zero = 1'b1;
        onehot     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (sh_bcd[4*i +: 4] == 4'd0);
            onehot[i]  = (idx == IW'(i));
            if (idx == IW'(i)) begin
                cur_bcd  = sh_bcd[4*i +: 4];
                cur_dp   = sh_dp[i];
                cur_bl   = sh_blink[i];
                cur_lead = (i != 0) && upper_zero;
            end
        end
    end

    always_comb begin
        seg_next = {cur_dp, (sh_lz && cur_lead) ? 7'h00 : decode(cur_bcd)};
        if (phase && cur_bl) begin
            seg_next = 8'h00;   // blink-off phase hides the dp too
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            fcnt       <= '0;
            phase      <= 1'b0;
            wrap_d     <= 1'b0;
            pend_bcd   <= '0;
            pend_dp    <= '0;
            pend_blink <= '0;
            pend_lz    <= 1'b0;
            pend_vld   <= 1'b0;
            sh_bcd     <= '0;
            sh_dp      <= '0;
            sh_blink   <= '0;
            sh_lz      <= 1'b0;
            seg_out    <= 8'h00;
            dig_sel    <= {DIGITS{DIG_ACT_LOW}};
            frame_stb  <= 1'b0;
        end else begin
            if (tc) begin
                cnt <= '0;
                idx <= last ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (wrap) begin
                // A load in the boundary cycle bypasses pending and shows this frame.
                if (load) begin
                    sh_bcd   <= bcd_in;
                    sh_dp    <= dp_in;
                    sh_blink <= blink_in;
                    sh_lz    <= blank_lz;
                end else if (pend_vld) begin
                    sh_bcd   <= pend_bcd;
                    sh_dp    <= pend_dp;
                    sh_blink <= pend_blink;
                    sh_lz    <= pend_lz;
                end
                pend_vld <= 1'b0;
                if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end else if (load) begin
                pend_bcd   <= bcd_in;
                pend_dp    <= dp_in;
                pend_blink <= blink_in;
                pend_lz    <= blank_lz;
                pend_vld   <= 1'b1;
            end

            seg_out   <= seg_next;
            dig_sel   <= DIG_ACT_LOW ? ~onehot : onehot;
            // Outputs lag idx by one cycle, so the strobe lags the wrap by two.
            wrap_d    <= wrap;
            frame_stb <= wrap_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a frame-level reference model.
// Latency: model predicts outputs after each rising edge from the edge count since reset release.
// Backpressure: n/a; loads are driven at random cycles, including frame-boundary cycles.
module tb_seg7_scan_driver;

    localparam int D  = 4;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FR = D * SD;   // cycles per frame

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [15:0]   bcd_in;
    logic [3:0]    dp_in;
    logic [3:0]    blink_in;
    logic          blank_lz;
    logic [7:0]    seg_out;
    logic [3:0]    dig_sel;
    logic          frame_stb;

    seg7_scan_driver #(
        .DIGITS(D), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .DIG_ACT_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
        .blink_in(blink_in), .blank_lz(blank_lz), .seg_out(seg_out),
        .dig_sel(dig_sel), .frame_stb(frame_stb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          e;     // edge number (since reset release) that sampled the load
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic [3:0]  bl;
        logic        lz;
    } load_t;

    load_t loads[$];
    int    n;               // rising edges since reset release
    int    n_checks = 0;
    int    n_pass   = 0;

    logic [6:0] seg_tab [0:9] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                  7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h (edge %0d, t=%0t)", tag, got, exp, n, $time);
    endtask

    // Data on display during frame f: latest load sampled at or before the edge
    // that starts frame f; frame 0 shows the reset contents.
    function automatic load_t frame_data(input int f);
        load_t r;
        r.e = 0; r.bcd = '0; r.dp = '0; r.bl = '0; r.lz = 1'b0;
        foreach (loads[i]) if (loads[i].e <= f * FR) r = loads[i];
        return r;
    endfunction

    task automatic check_outputs();
        int s, d, f, v;
        bit ph, blank;
        load_t r;
        logic [7:0] es;
        if (n == 0) begin
            chk("seg_rst", seg_out, 8'h00);
            chk("dig_rst", dig_sel, 4'hF);
            chk("stb_rst", frame_stb, 1'b0);
            return;
        end
        s  = (n - 1) / SD;
        d  = s % D;
        f  = s / D;
        r  = frame_data(f);
        ph = ((f / BF) % 2) == 1;
        v  = int'((r.bcd >> (4 * d)) & 16'hF);
        blank = r.lz && (d > 0) && ((r.bcd >> (4 * d)) == 16'h0);
        if (ph && r.bl[d]) es = 8'h00;
        else es = {r.dp[d], blank ? 7'h00 : (v <= 9 ? seg_tab[v] : 7'h00)};
        chk("seg", seg_out, es);
        chk("dig", dig_sel, 4'hF ^ (4'b0001 << d));
        chk("stb", frame_stb, (n > 1) && ((n - 1) % FR == 0));
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                for (int j = 0; j < D; j++)
                    bcd_in[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                dp_in    = 4'($urandom_range(0, 15));
                blink_in = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
                blank_lz = 1'($urandom_range(0, 1));
                load     = 1'b1;
                loads.push_back('{n + 1, bcd_in, dp_in, blink_in, blank_lz});
            end else begin
                load = 1'b0;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
            check_outputs();
        end
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; bcd_in = '0; dp_in = '0; blink_in = '0; blank_lz = 1'b0;
        n = 0;
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        run(1500);

        // Asynchronous reset in the middle of a digit slot.
        #2 rst_n = 1'b0;
        #1;
        chk("seg_async", seg_out, 8'h00);
        chk("dig_async", dig_sel, 4'hF);
        chk("stb_async", frame_stb, 1'b0);
        loads.delete();
        n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
        run(1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
